esc_pwm_multi: RTL and testbench

- Parametrised successor of the drone's 4-channel BLDC ESC pulse generator; sits between the I2C slave byte-capture stage and the ESC output pins.
- Parses a status/data byte stream and generates NUM_CH servo-style pulses, one per frame.
- New over the fixed 4-channel design:
  - atomic double-buffered updates at frame boundaries;
  - a link-loss failsafe watchdog;
  - optional per-frame slew limiting.

---
 rtl/esc_pkg.sv | 21 ++
 rtl/esc_pwm_multi_if.sv | 10 +
 rtl/esc_pwm_channel.sv | 59 +++++
 rtl/esc_pwm_multi.sv | 147 ++++++++++++++
 tb/tb_esc_pwm_multi.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/esc_pkg.sv
// Shared constants for the multi-channel ESC pulse generator: status bit
// positions, the full-scale data value and the default timing set.
package esc_pkg;

  localparam int STAT_PWM_ON   = 0;
  localparam int STAT_ONE_SHOT = 1;
  localparam int STAT_FS_EN    = 2;
  localparam int STAT_MARK     = 7;

  localparam logic [6:0] DATA_MAX = 7'h7F;

  localparam int          DEF_NUM_CH         = 4;
  localparam int          DEF_CNT_W          = 16;
  localparam logic [15:0] DEF_PERIOD_CNT     = 16'hA800;
  localparam logic [15:0] DEF_MIN_PULSE      = 16'h0810;
  localparam logic [15:0] DEF_MAX_PULSE      = 16'h1020;
  localparam int          DEF_SHIFT          = 4;
  localparam logic [15:0] DEF_MAX_STEP       = 16'h0000;
  localparam int          DEF_TIMEOUT_FRAMES = 25;

endpackage

// File: rtl/esc_pwm_multi_if.sv
// Byte-capture link from the I2C slave stage: one byte per rx_vld strobe.
interface esc_pwm_multi_if;

  logic [7:0] rx_data;
  logic       rx_vld;

  modport master (output rx_data, output rx_vld);
  modport slave  (input  rx_data, input  rx_vld);

endinterface

// File: rtl/esc_pwm_channel.sv
// One ESC output: maps a 7-bit command to a duty, optionally slews it once per
// frame, and drops the pulse when the frame counter passes the duty.
module esc_pwm_channel
  import esc_pkg::*;
#(
  parameter int               CNT_W     = DEF_CNT_W,
  parameter logic [CNT_W-1:0] MIN_PULSE = DEF_MIN_PULSE,
  parameter logic [CNT_W-1:0] MAX_PULSE = DEF_MAX_PULSE,
  parameter int               SHIFT     = DEF_SHIFT,
  parameter logic [CNT_W-1:0] MAX_STEP  = DEF_MAX_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             arm,
  input  logic             fs,
  input  logic [6:0]       value,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_reg;
  logic [CNT_W-1:0] duty_next;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] diff;

  always_comb begin
    target = MIN_PULSE;
    if (!fs) begin
      if (value == DATA_MAX) begin
        target = MAX_PULSE;
      end else begin
        target = MIN_PULSE + (CNT_W'(value) << SHIFT);
      end
    end
  end

  // Failsafe bypasses the slew limiter so the motors idle immediately.
  always_comb begin
    diff      = (target >= duty_reg) ? (target - duty_reg) : (duty_reg - target);
    duty_next = target;
    if (MAX_STEP != '0 && !fs && diff > MAX_STEP) begin
      duty_next = (target > duty_reg) ? (duty_reg + MAX_STEP) : (duty_reg - MAX_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_reg <= MIN_PULSE;
      pwm      <= 1'b0;
    end else if (tick) begin
      duty_reg <= duty_next;
      pwm      <= arm;
    end else if (cnt >= duty_reg) begin
      pwm <= 1'b0;
    end
  end

endmodule

// File: rtl/esc_pwm_multi.sv
// Multi-channel ESC pulse generator: parses status/data bytes, commits complete
// sets atomically at frame boundaries and falls back to idle on link loss.
module esc_pwm_multi
  import esc_pkg::*;
#(
  parameter int               NUM_CH         = DEF_NUM_CH,
  parameter int               CNT_W          = DEF_CNT_W,
  parameter logic [CNT_W-1:0] PERIOD_CNT     = DEF_PERIOD_CNT,
  parameter logic [CNT_W-1:0] MIN_PULSE      = DEF_MIN_PULSE,
  parameter logic [CNT_W-1:0] MAX_PULSE      = DEF_MAX_PULSE,
  parameter int               SHIFT          = DEF_SHIFT,
  parameter logic [CNT_W-1:0] MAX_STEP       = DEF_MAX_STEP,
  parameter int               TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
  input  logic              clk,
  input  logic              pin2,
  esc_pwm_multi_if.slave    rx,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_tick,
  output logic              armed,
  output logic              failsafe,
  output logic [7:0]        status_q
);

  localparam int               IDX_W    = $clog2(NUM_CH + 1);
  localparam int               WD_W     = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_CH);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_FRAMES);

  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       status_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             set_complete_reg;
  logic             one_shot_reg;
  logic [WD_W-1:0]  wd_reg;
  logic [WD_W-1:0]  wd_next;
  logic             failsafe_reg;
  logic             failsafe_next;
  logic             tick;
  logic             commit;
  logic             pulse_start;
  logic             is_status;
  logic             is_data;

  assign tick        = (cnt_reg == PERIOD_CNT);
  assign commit      = tick && set_complete_reg;
  assign pulse_start = status_reg[STAT_PWM_ON] || one_shot_reg;
  assign is_status   = rx.rx_vld && rx.rx_data[STAT_MARK];
  assign is_data     = rx.rx_vld && !rx.rx_data[STAT_MARK] && (idx_reg < IDX_END);

  always_comb begin
    wd_next = wd_reg;
    if (commit) begin
      wd_next = '0;
    end else if (wd_reg != WD_LIMIT) begin
      wd_next = wd_reg + WD_W'(1);
    end
    failsafe_next = 1'b0;
    if (!commit) begin
      failsafe_next = failsafe_reg || (status_reg[STAT_FS_EN] && (wd_next == WD_LIMIT));
    end
  end

  // Parser writes come after the tick updates so a set completing or a
  // one-shot request arriving on the tick cycle is not lost.
  always_ff @(posedge clk or negedge pin2) begin
    if (!pin2) begin
      cnt_reg          <= '0;
      status_reg       <= '0;
      idx_reg          <= IDX_END;
      set_complete_reg <= 1'b0;
      one_shot_reg     <= 1'b0;
      wd_reg           <= '0;
      failsafe_reg     <= 1'b0;
    end else begin
      if (tick) begin
        cnt_reg          <= '0;
        one_shot_reg     <= 1'b0;
        wd_reg           <= wd_next;
        failsafe_reg     <= failsafe_next;
        set_complete_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (is_status) begin
        status_reg       <= rx.rx_data;
        idx_reg          <= '0;
        set_complete_reg <= 1'b0;
        if (rx.rx_data[STAT_ONE_SHOT]) begin
          one_shot_reg <= 1'b1;
        end
      end else if (is_data) begin
        idx_reg <= idx_reg + IDX_W'(1);
        if (idx_reg == IDX_LAST) begin
          set_complete_reg <= 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [6:0] pending_reg;
    logic [6:0] shadow_reg;
    logic [6:0] value;

    always_ff @(posedge clk or negedge pin2) begin
      if (!pin2) begin
        pending_reg <= '0;
        shadow_reg  <= '0;
      end else begin
        if (is_data && (idx_reg == IDX_W'(gi))) begin
          pending_reg <= rx.rx_data[6:0];
        end
        if (commit) begin
          shadow_reg <= pending_reg;
        end
      end
    end

    // The committing frame already uses the new set.
    assign value = commit ? pending_reg : shadow_reg;

    esc_pwm_channel #(
      .CNT_W     (CNT_W),
      .MIN_PULSE (MIN_PULSE),
      .MAX_PULSE (MAX_PULSE),
      .SHIFT     (SHIFT),
      .MAX_STEP  (MAX_STEP)
    ) u_ch (
      .clk   (clk),
      .rst_n (pin2),
      .tick  (tick),
      .arm   (pulse_start),
      .fs    (failsafe_next),
      .value (value),
      .cnt   (cnt_reg),
      .pwm   (pwm_out[gi])
    );
  end

  assign frame_tick = tick;
  assign armed      = status_reg[STAT_PWM_ON];
  assign failsafe   = failsafe_reg;
  assign status_q   = status_reg;

endmodule

// File: tb/tb_esc_pwm_multi.sv
// Directed bench: a 4-channel instance without slew and a 1-channel instance
// with slew, both on a shortened 200-cycle frame, fed from one byte link.
module tb_esc_pwm_multi;

  localparam int FRAME = 200;

  logic       clk = 1'b0;
  logic       pin2;
  logic [3:0] pwm_m;
  logic [0:0] pwm_s;
  logic       ft_m, ft_s, armed_m, armed_s, fs_m, fs_s;
  logic [7:0] stat_m, stat_s;

  int errors = 0;
  int checks = 0;
  int wm[4];
  int ws;

  esc_pwm_multi_if bus();

  esc_pwm_multi #(
    .NUM_CH(4), .CNT_W(16), .PERIOD_CNT(16'd199), .MIN_PULSE(16'd16),
    .MAX_PULSE(16'd150), .SHIFT(0), .MAX_STEP(16'd0), .TIMEOUT_FRAMES(3)
  ) dut_m (
    .clk(clk), .pin2(pin2), .rx(bus), .pwm_out(pwm_m), .frame_tick(ft_m),
    .armed(armed_m), .failsafe(fs_m), .status_q(stat_m)
  );

  esc_pwm_multi #(
    .NUM_CH(1), .CNT_W(16), .PERIOD_CNT(16'd199), .MIN_PULSE(16'd16),
    .MAX_PULSE(16'd150), .SHIFT(0), .MAX_STEP(16'd40), .TIMEOUT_FRAMES(3)
  ) dut_s (
    .clk(clk), .pin2(pin2), .rx(bus), .pwm_out(pwm_s), .frame_tick(ft_s),
    .armed(armed_s), .failsafe(fs_s), .status_q(stat_s)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_vld  = 1'b1;
    @(negedge clk);
    bus.rx_vld  = 1'b0;
    $display("tx byte 0x%02h", b);
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ft_m && n < 2 * FRAME);
    checks++;
    if (ft_m !== 1'b1) begin
      errors++;
      $display("FAIL wait_tick: frame_tick got %b required 1 within %0d cycles", ft_m, 2 * FRAME);
    end
  endtask

  // Counts high cycles per output from the cycle after a tick up to the next tick.
  task automatic measure();
    for (int c = 0; c < 4; c++) wm[c] = 0;
    ws = 0;
    for (int n = 0; n < FRAME; n++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (pwm_m[c]) wm[c]++;
      if (pwm_s[0]) ws++;
    end
    $display("frame widths m=%0d/%0d/%0d/%0d s=%0d", wm[0], wm[1], wm[2], wm[3], ws);
  endtask

  task automatic test_reset();
    int exp_m[4];
    pin2 = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_vld  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pwm_m !== 4'h0 || pwm_s !== 1'b0) begin
      errors++; $display("FAIL reset_pwm: got %b/%b required 0000/0", pwm_m, pwm_s);
    end
    checks++;
    if (stat_m !== 8'h00 || armed_m !== 1'b0 || fs_m !== 1'b0) begin
      errors++; $display("FAIL reset_regs: status %h armed %b fs %b required 00 0 0", stat_m, armed_m, fs_m);
    end
    checks++;
    if (ft_m !== 1'b0) begin
      errors++; $display("FAIL reset_tick: got %b required 0", ft_m);
    end
    pin2 = 1'b1;
    @(negedge clk);
    // Data with no preceding status byte must be ignored.
    repeat (4) send_byte(8'h10);
    wait_tick();
    measure();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (wm[c] !== 0) begin
        errors++; $display("FAIL unarmed_width ch%0d: got %0d required 0", c, wm[c]);
      end
    end
    checks++;
    if (ft_m !== 1'b1 || ft_s !== 1'b1) begin
      errors++; $display("FAIL frame_period: tick %b/%b after %0d cycles required 1/1", ft_m, ft_s, FRAME);
    end
    @(negedge clk);
    send_byte(8'h81);
    wait_tick();
    measure();
    exp_m = '{17, 17, 17, 17};
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (wm[c] !== exp_m[c]) begin
        errors++; $display("FAIL predata_width ch%0d: got %0d required %0d", c, wm[c], exp_m[c]);
      end
    end
    checks++;
    if (ws !== 17) begin
      errors++; $display("FAIL predata_width_s: got %0d required 17", ws);
    end
  endtask

  task automatic test_basic();
    int exp_m[4];
    exp_m = '{17, 33, 81, 151};
    @(negedge clk);
    send_byte(8'h81); send_byte(8'h00); send_byte(8'h10); send_byte(8'h40); send_byte(8'h7F);
    checks++;
    if (stat_m !== 8'h81 || armed_m !== 1'b1 || armed_s !== 1'b1) begin
      errors++; $display("FAIL basic_status: status %h armed %b/%b required 81 1/1", stat_m, armed_m, armed_s);
    end
    wait_tick();
    for (int f = 0; f < 2; f++) begin
      measure();
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (wm[c] !== exp_m[c]) begin
          errors++; $display("FAIL basic_width f%0d ch%0d: got %0d required %0d", f, c, wm[c], exp_m[c]);
        end
      end
      checks++;
      if (ws !== 17) begin
        errors++; $display("FAIL basic_width_s f%0d: got %0d required 17", f, ws);
      end
    end
  endtask

  task automatic test_partial();
    int exp_m[4];
    exp_m = '{17, 33, 81, 151};
    @(negedge clk);
    send_byte(8'h81); send_byte(8'h20); send_byte(8'h20); send_byte(8'h81);
    wait_tick();
    measure();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (wm[c] !== exp_m[c]) begin
        errors++; $display("FAIL partial_width ch%0d: got %0d required %0d", c, wm[c], exp_m[c]);
      end
    end
    checks++;
    if (ws !== 17) begin
      errors++; $display("FAIL partial_width_s: got %0d required 17", ws);
    end
    checks++;
    if (fs_m !== 1'b0) begin
      errors++; $display("FAIL partial_failsafe: got %b required 0", fs_m);
    end
  endtask

  task automatic test_slew();
    int exp_s[5];
    exp_s = '{57, 97, 137, 151, 151};
    @(negedge clk);
    send_byte(8'h81); send_byte(8'h7F);
    wait_tick();
    for (int f = 0; f < 5; f++) begin
      measure();
      checks++;
      if (ws !== exp_s[f]) begin
        errors++; $display("FAIL slew_width f%0d: got %0d required %0d", f, ws, exp_s[f]);
      end
      checks++;
      if (wm[0] !== 17) begin
        errors++; $display("FAIL slew_main_hold f%0d: got %0d required 17", f, wm[0]);
      end
    end
  endtask

  task automatic test_failsafe();
    int exp_m[4];
    int exp_s[4];
    exp_m = '{17, 33, 81, 151};
    exp_s = '{111, 71, 31, 17};
    @(negedge clk);
    send_byte(8'h85); send_byte(8'h00); send_byte(8'h10); send_byte(8'h40); send_byte(8'h7F);
    wait_tick();
    for (int f = 0; f < 4; f++) begin
      measure();
      if (f == 2) begin
        checks++;
        if (fs_m !== 1'b0 || fs_s !== 1'b0) begin
          errors++; $display("FAIL failsafe_early: got %b/%b required 0/0", fs_m, fs_s);
        end
      end
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (wm[c] !== ((f == 3) ? 17 : exp_m[c])) begin
          errors++; $display("FAIL failsafe_width f%0d ch%0d: got %0d required %0d", f, c, wm[c], (f == 3) ? 17 : exp_m[c]);
        end
      end
      checks++;
      if (ws !== exp_s[f]) begin
        errors++; $display("FAIL failsafe_width_s f%0d: got %0d required %0d", f, ws, exp_s[f]);
      end
    end
    checks++;
    if (fs_m !== 1'b1 || fs_s !== 1'b1) begin
      errors++; $display("FAIL failsafe_trip: got %b/%b required 1/1", fs_m, fs_s);
    end
    @(negedge clk);
    send_byte(8'h85); send_byte(8'h7F); send_byte(8'h7F); send_byte(8'h7F); send_byte(8'h7F);
    wait_tick();
    measure();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (wm[c] !== 151) begin
        errors++; $display("FAIL failsafe_clear_width ch%0d: got %0d required 151", c, wm[c]);
      end
    end
    checks++;
    if (ws !== 57) begin
      errors++; $display("FAIL failsafe_clear_width_s: got %0d required 57", ws);
    end
    checks++;
    if (fs_m !== 1'b0 || fs_s !== 1'b0) begin
      errors++; $display("FAIL failsafe_clear: got %b/%b required 0/0", fs_m, fs_s);
    end
  endtask

  // The status byte lands exactly on the tick cycle; its one-shot must survive.
  task automatic test_one_shot();
    checks++;
    if (ft_m !== 1'b1) begin
      errors++; $display("FAIL oneshot_align: frame_tick got %b required 1", ft_m);
    end
    send_byte(8'h82);
    checks++;
    if (stat_m !== 8'h82 || armed_m !== 1'b0 || stat_s !== 8'h82) begin
      errors++; $display("FAIL oneshot_status: got %h/%h armed %b required 82/82 0", stat_m, stat_s, armed_m);
    end
    wait_tick();
    measure();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (wm[c] !== 151) begin
        errors++; $display("FAIL oneshot_width ch%0d: got %0d required 151", c, wm[c]);
      end
    end
    checks++;
    if (ws !== 137) begin
      errors++; $display("FAIL oneshot_width_s: got %0d required 137", ws);
    end
    measure();
    checks++;
    if (wm[0] + wm[1] + wm[2] + wm[3] + ws !== 0) begin
      errors++; $display("FAIL oneshot_after: got %0d high cycles required 0", wm[0] + wm[1] + wm[2] + wm[3] + ws);
    end
  endtask

  task automatic test_reset_midpulse();
    @(negedge clk);
    send_byte(8'h81);
    wait_tick();
    repeat (5) @(negedge clk);
    checks++;
    if (pwm_m !== 4'hF || pwm_s !== 1'b1) begin
      errors++; $display("FAIL midpulse_high: got %b/%b required 1111/1", pwm_m, pwm_s);
    end
    #2 pin2 = 1'b0;
    #1;
    checks++;
    if (pwm_m !== 4'h0 || pwm_s !== 1'b0) begin
      errors++; $display("FAIL midpulse_async: got %b/%b required 0000/0", pwm_m, pwm_s);
    end
    checks++;
    if (stat_m !== 8'h00 || fs_m !== 1'b0) begin
      errors++; $display("FAIL midpulse_regs: status %h fs %b required 00 0", stat_m, fs_m);
    end
    @(negedge clk);
    pin2 = 1'b1;
    wait_tick();
    measure();
    checks++;
    if (wm[0] + wm[1] + wm[2] + wm[3] + ws !== 0) begin
      errors++; $display("FAIL midpulse_after: got %0d high cycles required 0", wm[0] + wm[1] + wm[2] + wm[3] + ws);
    end
    checks++;
    if (armed_m !== 1'b0 || armed_s !== 1'b0) begin
      errors++; $display("FAIL midpulse_armed: got %b/%b required 0/0", armed_m, armed_s);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_slew();
    test_failsafe();
    test_one_shot();
    test_reset_midpulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
